csa_serial_adder_seq: RTL and testbench
=======================================

Name: csa_serial_adder_seq

Overview:
- Upstream sequencing stage for the 8-bit carry-skip adder datapath.
- Accepts byte-serial operand pairs (LSB byte first) over a valid/ready stream, drives an 8-bit carry-skip byte adder with a registered carry chain, and emits registered sum bytes downstream.
- Widens the 8-bit adder to multi-byte words of up to NBYTES bytes without widening the combinational path.

Parameters:
- NBYTES, 4, maximum bytes per word; word is force-terminated at this length.
- BLK_W, 4, carry-skip block width inside the byte adder; must divide 8.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand byte pair valid.
- in_ready  output  1  stage can accept a byte pair this cycle.
- in_a  input  8  operand A byte.
- in_b  input  8  operand B byte.
- in_last  input  1  marks the most-significant byte of the word.
- out_valid  output  1  out_sum / out_last / out_carry valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_sum  output  8  sum byte.
- out_last  output  1  marks the final byte of the word.
- out_carry  output  1  carry out of the final byte; 0 when out_last=0.
- len_err  output  1  sticky: a word hit NBYTES bytes without in_last.
- busy  output  1  high while in S_RUN or while out_valid=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_sum=0, out_last=0, out_carry=0, len_err=0.
  - Carry register=0, byte count=0, state=S_IDLE.
  - rst wins over any simultaneous handshake; a partially sent word is discarded with no output.
- Handshake:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (single output register; full throughput of one byte per cycle).
  - in_ready does not depend on in_valid.
- Latency: exactly 1 cycle from accept to out_valid=1.
  - out_* hold stable while out_valid & !out_ready.
- Datapath:
  - sum/cout = byte_add(in_a, in_b, cin).
  - cin = 0 in S_IDLE, else the carry register.
  - All arithmetic is modulo 2^8 per byte. The carry register captures cout on every accept.
- State machine:
  - S_IDLE: on accept with in_last=1, emit a single-byte word and stay in S_IDLE. On accept with in_last=0, go to S_RUN with count=1.
  - S_RUN: on accept, count increments.
    - If in_last=1, or count reaches NBYTES-1 before increment, out_last=1 and the stage returns to S_IDLE.
    - Carry register is cleared on returning to S_IDLE.
  - Forced termination (NBYTES reached, in_last=0): out_last=1 and len_err sets. The next byte starts a new word with cin=0.
- out_carry = cout of the final byte, registered alongside out_sum.
- No accept means no state change; the carry register holds across idle gaps mid-word.

Optional Feature:
- Macro CSA_SIGNED_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), valid with out_last.
  - out_ovf = signed two's-complement overflow of the whole word = cin_msb ^ cout_msb of the final byte's bit 7.
  - out_ovf is 0 on non-final bytes; reset value 0.
- Undefined: port absent; no extra logic.

Decomposition:
- Package csa_pkg:
  - BYTE_W=8.
  - Default BLK_W=4.
  - State enum {S_IDLE, S_RUN}.
  - Count width function clog2(NBYTES).
- Sub-module csa_byte_add: purely combinational, 8-bit a, b, cin -> sum, cout. Built from 8/BLK_W ripple blocks with block-propagate skip muxes.
- The sequencer instantiates exactly one csa_byte_add.

Test Plan:
- Single-byte word: a=0x7F, b=0x01, last=1 -> next cycle out_sum=0x80, out_last=1, out_carry=0 (OVF_EN: out_ovf=1).
- 2-byte word 0x01FF+0x0001, bytes (FF,01),(01,00,last) -> outputs 0x00 then 0x02/last; out_carry=0. Carry chain verified.
- Full-skip path: a=0xAA, b=0x55 mid-word with carry=1 -> out_sum=0x00, carry propagates to next byte; next byte (00,00,last) -> 0x01.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, no byte lost or duplicated once out_ready=1. Back-to-back words give 1 byte per cycle throughput.
- Length error with NBYTES=4: 5 bytes sent without last -> byte 4 carries out_last=1 and len_err=1; byte 5 starts a new word with cin=0.
- rst=1 pulsed mid-word after 2 bytes with out_valid=1 -> next cycle out_valid=0, len_err=0; subsequent word (0xFF+0x01, last) gives 0x00 with out_carry=1 (carry not leaked).

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths, state encoding and sizing helper for the carry-skip serial adder
package csa_pkg;

   localparam int BYTE_W    = 8;
   localparam int BLK_W_DEF = 4;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/csa_byte_add.sv
// rtl/csa_byte_add.sv - combinational 8-bit carry-skip adder built from BLK_W-bit ripple blocks
module csa_byte_add
   import csa_pkg::*;
#(
   parameter int BLK_W = BLK_W_DEF
) (
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   localparam int NBLK = BYTE_W / BLK_W;

   logic [BYTE_W-1:0] p;
   logic [BYTE_W-1:0] g;
   logic [NBLK:0]     cb;
   logic              rc;
   logic              bp;

   assign p = a ^ b;
   assign g = a & b;

   // Each block ripples internally; a fully propagating block forwards its
   // incoming carry directly, bypassing the ripple path.
   always_comb begin
      sum   = '0;
      cb    = '0;
      rc    = 1'b0;
      bp    = 1'b0;
      cb[0] = cin;
      for (int k = 0; k < NBLK; k++) begin
         rc = cb[k];
         bp = 1'b1;
         for (int i = 0; i < BLK_W; i++) begin
            sum[k*BLK_W+i] = p[k*BLK_W+i] ^ rc;
            rc             = g[k*BLK_W+i] | (p[k*BLK_W+i] & rc);
            bp             = bp & p[k*BLK_W+i];
         end
         cb[k+1] = bp ? cb[k] : rc;
      end
   end

   assign cout = cb[NBLK];

endmodule

// File: rtl/csa_serial_adder_seq.sv
// rtl/csa_serial_adder_seq.sv - byte-serial multi-byte adder sequencer with registered carry chain
// Optional CSA_SIGNED_OVF_EN adds out_ovf, the signed overflow of the completed word.
module csa_serial_adder_seq
   import csa_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int BLK_W  = BLK_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_a,
   input  logic [BYTE_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_sum,
   output logic              out_last,
   output logic              out_carry,
   output logic              len_err,
   output logic              busy
`ifdef CSA_SIGNED_OVF_EN
   ,
   output logic              out_ovf
`endif
);

   localparam int CNT_W = clog2(NBYTES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              carry_q;
   logic              cin;
   logic              accept;
   logic              word_end;
   logic              force_end;
   logic [BYTE_W-1:0] add_sum;
   logic              add_cout;

   csa_byte_add #(.BLK_W(BLK_W)) u_add (
      .a    (in_a),
      .b    (in_b),
      .cin  (cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && !in_last) state_nxt = S_RUN;
         S_RUN:   if (word_end)           state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = !out_valid || out_ready;
      accept    = in_valid && in_ready;
      cin       = (state == S_IDLE) ? 1'b0 : carry_q;
      force_end = accept && !in_last && (state == S_RUN) && (cnt == CNT_MAX);
      word_end  = accept && (in_last || force_end);
      busy      = (state == S_RUN) || out_valid;
   end

   // Carry and count only move on accept, so idle gaps mid-word are harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= 1'b0;
         cnt     <= '0;
         len_err <= 1'b0;
      end else if (accept) begin
         carry_q <= word_end ? 1'b0 : add_cout;
         cnt     <= word_end ? '0 : cnt + CNT_W'(1);
         if (force_end) len_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_last  <= 1'b0;
         out_carry <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_sum   <= add_sum;
         out_last  <= word_end;
         out_carry <= word_end && add_cout;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef CSA_SIGNED_OVF_EN
   logic msb_cin;
   // Carry into bit 7 recovered from the sum bit rather than exported by the adder.
   assign msb_cin = add_sum[BYTE_W-1] ^ in_a[BYTE_W-1] ^ in_b[BYTE_W-1];

   always_ff @(posedge clk) begin
      if (rst)         out_ovf <= 1'b0;
      else if (accept) out_ovf <= word_end && (msb_cin ^ add_cout);
   end
`endif

endmodule

// File: tb/tb_csa_serial_adder_seq.sv
// tb/tb_csa_serial_adder_seq.sv - directed self-checking bench for csa_serial_adder_seq
module tb_csa_serial_adder_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_last;
   logic       out_carry;
   logic       len_err;
   logic       busy;
`ifdef CSA_SIGNED_OVF_EN
   logic       out_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   csa_serial_adder_seq #(.NBYTES(4), .BLK_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_carry (out_carry),
      .len_err   (len_err),
      .busy      (busy)
`ifdef CSA_SIGNED_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
   endtask

   task automatic idle;
      in_valid = 1'b0;
      in_a     = 8'h00;
      in_b     = 8'h00;
      in_last  = 1'b0;
   endtask

   task automatic send_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic last, input logic [7:0] exp_sum,
                           input logic exp_last, input logic exp_carry);
      drive(a, b, last);
      check({tag, "_rdy"}, in_ready, 1);
      step();
      check({tag, "_vld"}, out_valid, 1);
      check({tag, "_sum"}, out_sum, exp_sum);
      check({tag, "_last"}, out_last, exp_last);
      check({tag, "_cry"}, out_carry, exp_carry);
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
      check("rst_vld", out_valid, 0);
      check("rst_sum", out_sum, 8'h00);
      check("rst_last", out_last, 0);
      check("rst_cry", out_carry, 0);
      check("rst_lerr", len_err, 0);
      check("rst_busy", busy, 0);
      check("rst_rdy", in_ready, 1);
`ifdef CSA_SIGNED_OVF_EN
      check("rst_ovf", out_ovf, 0);
`endif

      // single-byte word 0x7F + 0x01
      send_chk("one", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1, 1'b0);
`ifdef CSA_SIGNED_OVF_EN
      check("one_ovf", out_ovf, 1);
`endif
      idle();
      step();
      check("one_drain", out_valid, 0);

      // 0x01FF + 0x0001 across two bytes
      send_chk("w2b0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      check("w2b0_busy", busy, 1);
      send_chk("w2b1", 8'h01, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0);
`ifdef CSA_SIGNED_OVF_EN
      check("w2b1_ovf", out_ovf, 0);
`endif
      idle();
      step();

      // full-skip: AA+55 with carry in propagates straight through
      send_chk("skp0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      send_chk("skp1", 8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
      send_chk("skp2", 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0);
      idle();
      step();

      // backpressure: held output, stalled input, released once
      out_ready = 1'b0;
      send_chk("bp0", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      drive(8'h01, 8'h02, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("bp_stall_rdy", in_ready, 0);
         step();
         check("bp_stall_vld", out_valid, 1);
         check("bp_stall_sum", out_sum, 8'h30);
         check("bp_stall_last", out_last, 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_rel_rdy", in_ready, 1);
      step();
      check("bp1_vld", out_valid, 1);
      check("bp1_sum", out_sum, 8'h03);
      check("bp1_last", out_last, 1);
      idle();
      step();
      check("bp_nodup", out_valid, 0);

      // back-to-back single-byte words, one per cycle
      send_chk("b2b0", 8'h01, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0);
      send_chk("b2b1", 8'h02, 8'h02, 1'b1, 8'h04, 1'b1, 1'b0);
      send_chk("b2b2", 8'h80, 8'h83, 1'b1, 8'h03, 1'b1, 1'b1);
      idle();
      step();

      // forced termination at 4 bytes, fifth byte starts fresh with cin=0
      send_chk("len0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      send_chk("len1", 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
      send_chk("len2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      check("len2_err", len_err, 0);
      send_chk("len3", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
      check("len3_err", len_err, 1);
      send_chk("len4", 8'h05, 8'h00, 1'b1, 8'h05, 1'b1, 1'b0);
      check("len4_err", len_err, 1);
      idle();
      step();

      // reset mid-word: discards output and the pending carry
      send_chk("rw0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
      send_chk("rw1", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1 & 1'b0);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rw_vld", out_valid, 0);
      check("rw_lerr", len_err, 0);
      check("rw_busy", busy, 0);
      send_chk("rw2", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1);
`ifdef CSA_SIGNED_OVF_EN
      check("rw2_ovf", out_ovf, 0);
`endif
      idle();
      step();
      check("end_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
